// File: rtl/instr_fetch_unit.sv
// Instruction fetch / PC sequencing stage: fetches one word per instruction over a
// request/valid handshake, holds it for decode, then selects the next PC.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        Clock,
    input  logic        Resetn,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic [31:0] IMemRdata,
    input  logic        IMemValid,
    output logic [31:0] Inst,
    output logic [5:0]  OP,
    output logic [5:0]  Func,
    output logic        InstValid,
    input  logic        Jump,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        Stall,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        Fault,
    output logic [31:0] RetiredCount
);

    localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] inst_reg, inst_next;
    logic [31:0] retired_reg, retired_next;
    logic [31:0] tmo_cnt_reg, tmo_cnt_next;

    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] branch_offset;
    logic [31:0] branch_target;
    logic [31:0] next_pc;
    logic [31:0] tmo_inc;

    // Target computation; all additions wrap modulo 2^32.
    assign pc_plus4      = pc_reg + 32'd4;
    assign jump_target   = {pc_plus4[31:28], inst_reg[25:0], 2'b00};
    assign branch_offset = {{14{inst_reg[15]}}, inst_reg[15:0], 2'b00};
    assign branch_target = pc_plus4 + branch_offset;
    assign tmo_inc       = tmo_cnt_reg + 32'd1;

    // Jump takes priority over a taken branch.
    always_comb begin
        next_pc = pc_plus4;
        if (Jump) begin
            next_pc = jump_target;
        end else if (Branch && Zero) begin
            next_pc = branch_target;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_reg   <= IDLE;
            pc_reg      <= RESET_PC;
            inst_reg    <= 32'd0;
            retired_reg <= 32'd0;
            tmo_cnt_reg <= 32'd0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            inst_reg    <= inst_next;
            retired_reg <= retired_next;
            tmo_cnt_reg <= tmo_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        inst_next    = inst_reg;
        retired_next = retired_reg;
        tmo_cnt_next = tmo_cnt_reg;
        case (state_reg)
            IDLE: begin
                tmo_cnt_next = 32'd0;
                state_next   = FETCH;
            end
            FETCH: begin
                if (IMemValid) begin
                    inst_next    = IMemRdata;
                    tmo_cnt_next = 32'd0;
                    state_next   = EXEC;
                end else begin
                    tmo_cnt_next = tmo_inc;
                    // A zero limit disables the timeout entirely.
                    if ((TMO_LIMIT != 32'd0) && (tmo_inc == TMO_LIMIT)) begin
                        state_next = FAULT;
                    end
                end
            end
            EXEC: begin
                if (!Stall) begin
                    pc_next      = next_pc;
                    retired_next = retired_reg + 32'd1;
                    state_next   = FETCH;
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Status outputs decode straight from state so reset drops them without a clock edge.
    assign IMemReq      = (state_reg == FETCH);
    assign InstValid    = (state_reg == EXEC);
    assign Fault        = (state_reg == FAULT);
    assign IMemAddr     = pc_reg;
    assign PC           = pc_reg;
    assign PCPlus4      = pc_plus4;
    assign Inst         = inst_reg;
    assign OP           = inst_reg[31:26];
    assign Func         = inst_reg[5:0];
    assign RetiredCount = retired_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, jump/branch targets, wait
// states with stall, fetch timeout fault, PC wrap and asynchronous reset.
module tb_instr_fetch_unit;

    logic        Clock;
    logic        Resetn;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic [31:0] IMemRdata;
    logic        IMemValid;
    logic [31:0] Inst;
    logic [5:0]  OP;
    logic [5:0]  Func;
    logic        InstValid;
    logic        Jump;
    logic        Branch;
    logic        Zero;
    logic        Stall;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        Fault;
    logic [31:0] RetiredCount;

    int          n_checks;
    int          n_errors;
    logic [31:0] exp_ret;
    logic [31:0] tmp;

    instr_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .TIMEOUT (4)
    ) dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .IMemReq     (IMemReq),
        .IMemAddr    (IMemAddr),
        .IMemRdata   (IMemRdata),
        .IMemValid   (IMemValid),
        .Inst        (Inst),
        .OP          (OP),
        .Func        (Func),
        .InstValid   (InstValid),
        .Jump        (Jump),
        .Branch      (Branch),
        .Zero        (Zero),
        .Stall       (Stall),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .Fault       (Fault),
        .RetiredCount(RetiredCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, want);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(negedge Clock);
    endtask

    // Starts at a negedge in FETCH; ends at a negedge in the following FETCH.
    task automatic run_instr(input logic [31:0] word, input int waits, input logic j,
                             input logic b, input logic z, input logic [31:0] exp_pc,
                             input logic [31:0] exp_next);
        logic [31:0] p4;
        p4 = exp_pc + 32'd4;
        for (int i = 0; i < waits; i++) begin
            check("wait_addr", IMemAddr, exp_pc);
            check("wait_req", IMemReq, 1'b1);
            IMemValid = 1'b0;
            IMemRdata = $urandom;
            tick();
        end
        check("fetch_addr", IMemAddr, exp_pc);
        check("fetch_req", IMemReq, 1'b1);
        check("fetch_instvalid", InstValid, 1'b0);
        IMemValid = 1'b1;
        IMemRdata = word;
        tick();
        IMemValid = 1'b0;
        IMemRdata = 32'hDEAD_BEEF;
        check("exec_instvalid", InstValid, 1'b1);
        check("exec_req", IMemReq, 1'b0);
        check("exec_inst", Inst, word);
        check("exec_pcplus4", PCPlus4, p4);
        Jump   = j;
        Branch = b;
        Zero   = z;
        tick();
        Jump   = 1'b0;
        Branch = 1'b0;
        Zero   = 1'b0;
        exp_ret = exp_ret + 32'd1;
        check("next_addr", IMemAddr, exp_next);
        check("retired", RetiredCount, exp_ret);
    endtask

    // Pulses Resetn from a negedge; returns at the negedge of the first FETCH cycle.
    task automatic do_reset();
        Resetn = 1'b0;
        #1;
        check("rst_req", IMemReq, 1'b0);
        check("rst_fault", Fault, 1'b0);
        check("rst_pc", PC, 32'h0);
        check("rst_inst", Inst, 32'h0);
        check("rst_retired", RetiredCount, 32'h0);
        tick();
        Resetn = 1'b1;
        tick();
        exp_ret = 32'd0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        exp_ret   = 32'd0;
        Resetn    = 1'b0;
        IMemRdata = 32'h0;
        IMemValid = 1'b0;
        Jump      = 1'b0;
        Branch    = 1'b0;
        Zero      = 1'b0;
        Stall     = 1'b0;

        // Reset state, then the IDLE cycle.
        tick();
        check("reset_pc", PC, 32'h0);
        check("reset_inst", Inst, 32'h0);
        check("reset_op", OP, 6'h0);
        check("reset_func", Func, 6'h0);
        check("reset_instvalid", InstValid, 1'b0);
        check("reset_req", IMemReq, 1'b0);
        check("reset_fault", Fault, 1'b0);
        check("reset_retired", RetiredCount, 32'h0);
        Resetn = 1'b1;
        #1;
        check("idle_req", IMemReq, 1'b0);
        tick();
        check("first_req", IMemReq, 1'b1);

        // Zero-wait sequential fetch: 0,4,8,C then 0x10 with four retired.
        run_instr(32'h0000_0020, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4);
        run_instr(32'h0000_0022, 0, 1'b0, 1'b0, 1'b0, 32'h4, 32'h8);
        run_instr(32'h0000_0024, 0, 1'b0, 1'b0, 1'b0, 32'h8, 32'hC);
        run_instr(32'h0000_0025, 0, 1'b0, 1'b0, 1'b0, 32'hC, 32'h10);
        check("seq_retired4", RetiredCount, 32'd4);

        // Jump from PC=0, then Jump+Branch+Zero: jump wins.
        tick();
        do_reset();
        IMemValid = 1'b1;
        IMemRdata = 32'h0800_0010;
        tick();
        IMemValid = 1'b0;
        check("jump_op", OP, 6'h02);
        check("jump_func", Func, 6'h10);
        Jump = 1'b1;
        tick();
        Jump = 1'b0;
        exp_ret = exp_ret + 32'd1;
        check("jump_addr", IMemAddr, 32'h0000_0040);
        run_instr(32'h0800_0010, 0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h40);
        run_instr(32'h0800_0040, 0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h100);

        // Branch at 0x100 with offset -1 word: taken -> 0x100, not taken -> 0x104.
        run_instr(32'h1000_FFFF, 0, 1'b0, 1'b1, 1'b1, 32'h100, 32'h100);
        run_instr(32'h1000_FFFF, 0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h104);

        // Three wait cycles with changing data, then five stalled EXEC cycles.
        for (int i = 0; i < 3; i++) begin
            check("wait3_addr", IMemAddr, 32'h104);
            check("wait3_req", IMemReq, 1'b1);
            IMemValid = 1'b0;
            IMemRdata = 32'hA5A5_0000 + 32'(i);
            tick();
        end
        check("wait3_addr_valid", IMemAddr, 32'h104);
        IMemValid = 1'b1;
        IMemRdata = 32'h2108_0001;
        tick();
        check("wait3_inst", Inst, 32'h2108_0001);
        Stall     = 1'b1;
        IMemRdata = 32'hFFFF_0000;
        for (int i = 0; i < 5; i++) begin
            check("stall_instvalid", InstValid, 1'b1);
            check("stall_pc", PC, 32'h104);
            check("stall_retired", RetiredCount, exp_ret);
            check("stall_inst", Inst, 32'h2108_0001);
            tick();
        end
        check("stall_end_instvalid", InstValid, 1'b1);
        Stall     = 1'b0;
        IMemValid = 1'b0;
        tick();
        exp_ret = exp_ret + 32'd1;
        check("stall_next_addr", IMemAddr, 32'h108);
        check("stall_next_retired", RetiredCount, exp_ret);

        // Timeout: four non-valid FETCH cycles, then sticky fault.
        for (int i = 0; i < 4; i++) begin
            check("tmo_fault_low", Fault, 1'b0);
            check("tmo_req", IMemReq, 1'b1);
            tick();
        end
        check("tmo_fault", Fault, 1'b1);
        check("tmo_req_low", IMemReq, 1'b0);
        check("tmo_instvalid", InstValid, 1'b0);
        check("tmo_pc", PC, 32'h108);
        IMemValid = 1'b1;
        IMemRdata = 32'h1234_5678;
        tick();
        tick();
        IMemValid = 1'b0;
        check("tmo_sticky", Fault, 1'b1);
        check("tmo_inst_kept", Inst, 32'h2108_0001);
        check("tmo_pc_frozen", PC, 32'h108);
        do_reset();
        check("tmo_cleared", Fault, 1'b0);

        // Branch back to 0xFFFF_FFFC, sequential wrap to 0.
        run_instr(32'h1000_FFFE, 0, 1'b0, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFC);
        run_instr(32'h0000_0020, 1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0);

        // Asynchronous reset mid-FETCH, between clock edges.
        check("mid_req_before", IMemReq, 1'b1);
        #2;
        Resetn = 1'b0;
        #1;
        check("mid_req", IMemReq, 1'b0);
        check("mid_inst", Inst, 32'h0);
        check("mid_pc", PC, 32'h0);
        check("mid_retired", RetiredCount, 32'h0);
        tick();
        Resetn = 1'b1;
        tick();
        check("after_mid_req", IMemReq, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
